// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-stage access unit.
//   - state_e      : access sequencer states
//   - OFF_*        : per-channel register offsets inside a 16-byte channel window
//   - STATUS_*_BIT : bit positions inside the STATUS register
package mem_stage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MMIO,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_e;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_ARG    = 4'h8;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

endpackage

// File: rtl/mem_stage_mmio_if.sv
// mem_stage_mmio_if: bundles the pipeline, cache and accelerator signals of
// the memory stage.
//   slave  : the access unit (consumes requests, drives cache/accelerator side)
//   master : the surrounding pipeline/cache/accelerators
interface mem_stage_mmio_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4
);
    // pipeline side
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic                     req_wr;
    logic                     req_en;
    logic                     stall;
    logic                     done;
    logic [DATA_W-1:0]        rdata;
    // cache side
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_wr;
    logic                     mem_en;
    logic                     mem_done;
    logic [DATA_W-1:0]        mem_rdata;
    // accelerator side
    logic [NUM_CH-1:0]        acc_start;
    logic [NUM_CH*DATA_W-1:0] acc_arg;
    logic [NUM_CH-1:0]        acc_busy;
    logic [NUM_CH-1:0]        acc_done;

    modport slave (
        input  req_addr, req_wdata, req_wr, req_en, mem_done, mem_rdata,
               acc_busy, acc_done,
        output stall, done, rdata, mem_addr, mem_wdata, mem_wr, mem_en,
               acc_start, acc_arg
    );

    modport master (
        output req_addr, req_wdata, req_wr, req_en, mem_done, mem_rdata,
               acc_busy, acc_done,
        input  stall, done, rdata, mem_addr, mem_wdata, mem_wr, mem_en,
               acc_start, acc_arg
    );

endinterface

// File: rtl/mmio_channel_regs.sv
// mmio_channel_regs: register file of one accelerator channel.
//   clk, rst  : clock, synchronous active-high reset
//   sel, wr   : this channel is addressed this cycle / access is a store
//   off       : register offset within the channel window
//   wdata     : store data
//   busy      : accelerator busy level
//   acc_done  : accelerator completion pulse (sets sticky DONE)
//   arg       : ARG register contents
//   start     : registered start pulse
//   rd_data   : read value of the register at 'off' (not gated by sel)
module mmio_channel_regs
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              wr,
    input  logic [3:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic              busy,
    input  logic              acc_done,
    output logic [DATA_W-1:0] arg,
    output logic              start,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] arg_q, arg_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              start_q, start_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        arg_d   = arg_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        if (sel && wr) begin
            case (off)
                OFF_CTRL: begin
                    if (wdata[0]) begin
                        if (busy) err_d   = 1'b1;
                        else      start_d = 1'b1;
                    end
                end
                OFF_STATUS: begin
                    if (wdata[STATUS_DONE_BIT]) done_d = 1'b0;
                    if (wdata[STATUS_ERR_BIT])  err_d  = 1'b0;
                end
                OFF_ARG: arg_d = wdata;
                default: ;
            endcase
        end
        // Evaluated after the write-1-clear so a coincident completion wins.
        if (acc_done) done_d = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data[0] = busy;
            OFF_STATUS: begin
                rd_data[STATUS_DONE_BIT] = done_q;
                rd_data[STATUS_ERR_BIT]  = err_q;
            end
            OFF_ARG:    rd_data = arg_q;
            default:    ;
        endcase
    end

    // NOTE: the ARG storage is a handful of flops, not a RAM, so it is reset
    // along with everything else; accelerators never see a stale argument.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            arg_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            arg_q   <= arg_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    assign arg   = arg_q;
    assign start = start_q;

endmodule

// File: rtl/mem_stage_mmio.sv
// mem_stage_mmio: memory-stage access unit. Routes each load/store either to
// the data cache (request/done handshake) or to a 256-byte MMIO window of
// NUM_CH accelerator channels, and stalls the pipeline until completion.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_stage_mmio_if.slave (pipeline request/response, cache
//              request/completion, accelerator start/arg/busy/done)
module mem_stage_mmio
    import mem_stage_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter int               NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_mmio_if.slave       bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              hit;
    logic [3:0]        ch;
    logic [DATA_W-1:0] mmio_rd;
    logic [DATA_W-1:0] ch_arg   [NUM_CH];
    logic [DATA_W-1:0] ch_rd    [NUM_CH];
    logic              ch_start [NUM_CH];

    assign hit = (bus.req_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]);
    assign ch  = addr_q[7:4];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mmio_channel_regs #(.DATA_W(DATA_W)) u_regs (
            .clk      (clk),
            .rst      (rst),
            .sel      ((state_q == MMIO) && (ch == 4'(c))),
            .wr       (wr_q),
            .off      (addr_q[3:0]),
            .wdata    (wdata_q),
            .busy     (bus.acc_busy[c]),
            .acc_done (bus.acc_done[c]),
            .arg      (ch_arg[c]),
            .start    (ch_start[c]),
            .rd_data  (ch_rd[c])
        );
    end

    // Channels at or above NUM_CH match nothing and read as zero.
    always_comb begin
        mmio_rd       = '0;
        bus.acc_arg   = '0;
        bus.acc_start = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.acc_arg[c*DATA_W +: DATA_W] = ch_arg[c];
            bus.acc_start[c]                = ch_start[c];
            if (ch == 4'(c)) mmio_rd = ch_rd[c];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_en) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wr_d    = bus.req_wr;
                    state_d = hit ? MMIO : MEM_REQ;
                end
            end
            MMIO: begin
                rdata_d = wr_q ? '0 : mmio_rd;
                state_d = RESP;
            end
            // The cache may complete in the same cycle as the request.
            MEM_REQ, MEM_WAIT: begin
                if (bus.mem_done) begin
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // The latched request doubles as the registered cache request.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_en    = (state_q == MEM_REQ);
    assign bus.done      = (state_q == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.stall     = bus.req_en && !bus.done;

endmodule

// File: doc/mem_stage_mmio.md
# mem_stage_mmio

Parametrised memory-stage access unit for the pipeline. It sits between the EX/MEM pipeline register and the data cache (mem_system). Each load/store is sent either to the cache, through a request/done handshake, or to a decoded MMIO window of NUM_CH accelerator channels. It replaces the single hard-wired FPU start decode with per-channel start, argument and sticky-status registers, and it stalls the pipeline until every access completes.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be ≥ 2.
- NUM_CH, 4: number of accelerator channels; range 1..16.
- MMIO_BASE, 32'h1000_0000: base address of the MMIO window; must be aligned to a 256-byte boundary.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_addr  in  ADDR_W  access address, from the ALU result.
- req_wdata  in  DATA_W  store data.
- req_wr  in  1  1 = store, 0 = load; qualified by req_en.
- req_en  in  1  access request; held stable by the pipeline while stall=1.
- stall  out  1  stall request to the pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  load data; valid while done=1.
- mem_addr  out  ADDR_W  cache request address.
- mem_wdata  out  DATA_W  cache store data.
- mem_wr  out  1  cache store flag.
- mem_en  out  1  one-cycle cache request pulse.
- mem_done  in  1  cache completion pulse.
- mem_rdata  in  DATA_W  cache load data; valid with mem_done.
- acc_start  out  NUM_CH  per-channel start pulse.
- acc_arg  out  NUM_CH*DATA_W  per-channel argument registers; channel c occupies bits [c*DATA_W +: DATA_W].
- acc_busy  in  NUM_CH  accelerator busy level.
- acc_done  in  NUM_CH  accelerator completion pulse.

## Operation
- **Address decode.**
  - MMIO hit when req_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8].
  - Channel index: ch = req_addr[7:4].
  - Register offset: req_addr[3:0].
- **Channel registers.** Each channel has 16 bytes of register space:
  - 0x0 CTRL
    - Write with bit0=1: pulse acc_start[ch] if acc_busy[ch]=0. If acc_busy[ch]=1, no pulse and ERR is set instead.
    - Read: {0…, acc_busy[ch]}.
  - 0x4 STATUS: bit0 DONE (sticky), bit1 ERR (sticky).
    - Read returns {0…, ERR, DONE}.
    - Write 1 to a bit clears that bit.
  - 0x8 ARG: read/write, full DATA_W.
  - 0xC, other unaligned offsets, and ch ≥ NUM_CH: reads return 0, writes are ignored, and the access still completes normally.
- **DONE.** Set on an acc_done[ch] pulse. If a set and a write-1-clear occur in the same cycle, set wins.
- **FSM states:** IDLE, MMIO, MEM_REQ, MEM_WAIT, RESP.
  - IDLE, req_en=1 and MMIO hit → MMIO.
  - IDLE, req_en=1 and not a hit → MEM_REQ.
  - MMIO: perform the register read/write and latch rdata → RESP.
  - MEM_REQ: mem_en=1 for this cycle only; mem_addr/mem_wdata/mem_wr are registered copies of the request → MEM_WAIT.
    - If mem_done is already 1 in this cycle, latch mem_rdata → RESP.
  - MEM_WAIT: hold until mem_done=1, then latch mem_rdata → RESP.
  - RESP: done=1 → IDLE.
- **stall** = req_en && !done. The pipeline advances on the done cycle, so a request held stable is never issued twice.
- Store completions drive rdata = 0.
- **Reset values:** all outputs 0, acc_arg 0, DONE/ERR 0, state IDLE.
- **Reset mid-operation:** an access in flight is abandoned. A mem_done arriving while in IDLE is ignored.

## Timing
- MMIO access: request seen in IDLE in cycle T; register update at the end of T+1; done and acc_start pulse coincide at T+2 and each last exactly one cycle.
- Cache access: mem_en is high in T+1. A mem_done at cycle D gives done at D+1, with a minimum of T+2.
- acc_done arriving in the same cycle as a STATUS read: the read returns the pre-update value, and DONE is visible on the next read.
- stall is combinational from req_en and state. No other input-to-output combinational paths exist.

## Structure
- **Package mem_stage_pkg:**
  - FSM state enum.
  - Register offset constants: CTRL=4'h0, STATUS=4'h4, ARG=4'h8.
  - STATUS bit indices.
- **Sub-module mmio_channel_regs:** one channel's ARG, DONE and ERR storage and start logic. Instantiate it NUM_CH times with a generate loop.

## Test plan
- **Cache load.** Load from 0x0000_0100; the cache model returns 0xDEAD_BEEF after 3 cycles. Expect: exactly one mem_en pulse, stall held until done, rdata=0xDEAD_BEEF.
- **Start with argument.** Store 0x55 to ARG of ch2 (0x1000_0028), then store 1 to CTRL of ch2 (0x1000_0020) with busy=0. Expect: acc_arg ch2 = 0x55, acc_start=4'b0100 for one cycle, no mem_en.
- **Start while busy.** CTRL write to ch1 with acc_busy[1]=1. Expect: no start pulse, STATUS of ch1 reads 0x2. Then write 0x2 to STATUS of ch1; it reads 0x0.
- **Done set/clear collision.** acc_done[0] pulses in the same cycle as a write of 1 to STATUS of ch0. Expect: the next STATUS read returns 0x1.
- **Out-of-range channel.** With NUM_CH=4, access ch5 (0x1000_0050). Expect: read returns 0, done at T+2, no channel state changes.
- **Reset mid-access.** Assert rst during MEM_WAIT, then the cache's mem_done arrives. Expect: state IDLE, done never pulses, all outputs 0.
